prf_wb_arbiter: RTL and testbench
=================================

# prf_wb_arbiter

Writeback arbiter for the physical register file. It collects completed results from `NUM_REQ` functional-unit requesters into per-requester holding slots. Each cycle it selects up to `` `N `` buffered results in round-robin order and drives them, registered, onto the PRF's `` `N `` write lanes. It sits between the execute stage and the PRF write port, so more FUs than write lanes can complete in the same cycle without losing results.

## Interface
Parameters:
- `NUM_REQ`, default 6: number of requesters. Must be ≥ 1. `NUM_REQ` ≤ `` `N `` is legal; every buffered slot is then granted each cycle.

Ports (types from `sys_defs.svh`; `PRF_WRITE` = {`DATA value`, `PRN prn`}; `prn == 0` means no write):
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `squash`, in, 1: mispredict flush; drops all buffered and staged results.
- `req_valid`, in, `[NUM_REQ-1:0]`: requester i presents a result.
- `req_data`, in, `PRF_WRITE [NUM_REQ-1:0]`: result for requester i.
- `req_ready`, out, `[NUM_REQ-1:0]`: slot i accepts this cycle.
- `write_data`, out, `PRF_WRITE [`N-1:0]`: registered PRF write lanes; `prn == 0` means an idle lane.
- `pending_count`, out, `$clog2(NUM_REQ+1)`: number of occupied slots (registered state).

## Operation
- **State:**
  - `slot_valid[i]` and `slot_data[i]` per requester.
  - `rr_ptr`, width `$clog2(NUM_REQ)`.
  - `write_data` output register.
- **Selection (combinational, state-only):**
  - Scan slots circularly from `rr_ptr`.
  - The first up to `` `N `` valid slots are granted.
  - The k-th grant in scan order goes to lane k; lanes beyond the grant count carry `prn = 0` and `value = 0`.
- **Ready:** `req_ready[i] = !reset && !squash && (!slot_valid[i] || grant[i])`. Ready depends only on state, so there is no combinational path from `req_valid` to `req_ready`.
- **Accept:** `req_valid[i] && req_ready[i]` with `req_data[i].prn != 0` loads slot i at the next edge. If `prn == 0`, the transfer handshakes but is discarded and the slot stays empty.
- **Grant:** a granted slot clears at the next edge unless it is refilled in the same cycle. The granted entries load `write_data` at that edge.
- **Pointer:** if at least one grant, `rr_ptr` becomes (index of last granted slot + 1) mod `NUM_REQ`; otherwise `rr_ptr` holds.
- **Squash:**
  - At the next edge, all `slot_valid` clear and `write_data` becomes all-zero.
  - `rr_ptr` holds its value.
  - Grants computed in the squash cycle are discarded.
- **Duplicate PRNs:** the block does not check for them; upstream guarantees at most one in-flight writer per PRN.

## Timing
- **Reset values:**
  - all slots empty
  - `rr_ptr = 0`
  - `write_data` all-zero
  - `pending_count = 0`
  - `req_ready = 0` while `reset` is high
- **Latency:** a result accepted at edge t is granted in the cycle after t, appears on `write_data` after edge t+1, and the PRF captures it at edge t+2. Minimum is 2 cycles from handshake to PRF state.
- **Throughput:** one result per requester per cycle (refill on grant); at most `` `N `` results in total per cycle.
- **Fairness:** a valid slot is granted within `ceil(NUM_REQ / `N)` cycles.
- **Full:** an occupied, ungranted slot holds `req_ready[i] = 0`. The requester must hold `req_valid` and `req_data` stable until ready.
- **Reset or squash mid-operation:** takes priority over accept and grant. No partial state survives.

## Configuration
- **`PRF_WB_ARB_STATS_EN` defined:** adds two outputs.
  - `stat_grants`, 32-bit: total results granted.
  - `stat_conflicts`, 32-bit: cycles in which more than `` `N `` slots were valid.
  - Both counters saturate, clear on `reset`, and are not affected by `squash`.
- **Undefined:** the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- **Single result:** after reset, req 0 presents {value=0xDEAD, prn=40} for one cycle → `req_ready[0] = 1`; two cycles later lane 0 = {0xDEAD, 40} and other lanes have prn 0; `pending_count` returns to 0.
- **Oversubscription:** with `` `N = 2 ``, `NUM_REQ = 6`, all six requesters present once at cycle 0 with prn 33–38 → lanes carry 33/34, then 35/36, then 37/38 on consecutive cycles; `rr_ptr` goes 0→2→4→0.
- **Back-pressure:** hold req 5 valid continuously while req 0–4 also stream → req 5 is granted within 3 cycles and is never starved; `req_ready` is 0 only while its slot is held.
- **Squash:** with 4 slots pending, assert `squash` for one cycle → the next cycle has all lanes at prn 0, `pending_count = 0`, and no pending PRN is ever written.
- **prn 0 request:** req 2 presents prn 0 → handshake completes, no slot fills, and nothing appears on any lane.
- **Stats (`PRF_WB_ARB_STATS_EN` defined):** run the oversubscription test → `stat_grants = 6` and `stat_conflicts = 2`.

Source files
------------

// File: rtl/prf_wb_arbiter_if.sv
// rtl/prf_wb_arbiter_if.sv - PRF write types and requester/PRF-lane bus for prf_wb_arbiter
`ifndef N
`define N 2
`endif

package prf_wb_arbiter_pkg;
  typedef logic [31:0] DATA;
  typedef logic [5:0]  PRN;
  // prn == 0 marks an empty write
  typedef struct packed {
    DATA value;
    PRN  prn;
  } PRF_WRITE;
endpackage

interface prf_wb_arbiter_if #(
  parameter int NUM_REQ = 6,
  parameter int N_LANES = `N
);
  import prf_wb_arbiter_pkg::*;
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic     [NUM_REQ-1:0] req_valid;
  PRF_WRITE [NUM_REQ-1:0] req_data;
  logic     [NUM_REQ-1:0] req_ready;
  PRF_WRITE [N_LANES-1:0] write_data;
  logic     [CNT_W-1:0]   pending_count;

  // Execute-side view: presents results, observes ready and the PRF lanes
  modport master (
    output req_valid, req_data,
    input  req_ready, write_data, pending_count
  );

  // Arbiter view
  modport slave (
    input  req_valid, req_data,
    output req_ready, write_data, pending_count
  );
endinterface

// File: rtl/prf_wb_arbiter.sv
// rtl/prf_wb_arbiter.sv - round-robin PRF writeback arbiter; optional counters under PRF_WB_ARB_STATS_EN
`ifndef N
`define N 2
`endif

module prf_wb_arbiter
  import prf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  squash,
  prf_wb_arbiter_if.slave       bus
`ifdef PRF_WB_ARB_STATS_EN
  ,
  output logic [31:0]           stat_grants,
  output logic [31:0]           stat_conflicts
`endif
);

  localparam int LANES = `N;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  logic     [NUM_REQ-1:0] slot_valid;
  PRF_WRITE [NUM_REQ-1:0] slot_data;
  logic     [PTR_W-1:0]   rr_ptr;

  logic     [NUM_REQ-1:0] grant;
  PRF_WRITE [LANES-1:0]   lane_next;
  int                     grant_cnt;
  int                     last_idx;
  logic                   in_pass;
  logic     [PTR_W-1:0]   rr_next;
  logic     [CNT_W-1:0]   valid_cnt;

  // Circular scan from rr_ptr: first pass covers rr_ptr..end, second pass wraps to 0..rr_ptr-1
  always_comb begin
    grant     = '0;
    lane_next = '0;
    grant_cnt = 0;
    last_idx  = 0;
    in_pass   = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        in_pass = (pass == 0) ? (i >= int'(rr_ptr)) : (i < int'(rr_ptr));
        if (in_pass && slot_valid[i] && (grant_cnt < LANES)) begin
          grant[i] = 1'b1;
          for (int l = 0; l < LANES; l++) begin
            if (grant_cnt == l) begin
              lane_next[l] = slot_data[i];
            end
          end
          grant_cnt = grant_cnt + 1;
          last_idx  = i;
        end
      end
    end
  end

  // Pointer moves just past the last granted slot
  always_comb begin
    rr_next = rr_ptr;
    if (grant_cnt > 0) begin
      rr_next = (last_idx + 1 >= NUM_REQ) ? '0 : PTR_W'(last_idx + 1);
    end
  end

  // Occupancy is derived purely from slot state
  always_comb begin
    valid_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      valid_cnt = valid_cnt + CNT_W'(slot_valid[i]);
    end
  end

  // Ready depends on state only, so req_valid never feeds back into req_ready
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = !reset && !squash && (!slot_valid[i] || grant[i]);
    end
  end

  assign bus.pending_count = valid_cnt;

  // Slot fill/drain, output lanes and round-robin pointer; reset and squash override all traffic
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid     <= '0;
      slot_data      <= '0;
      rr_ptr         <= '0;
      bus.write_data <= '0;
    end else if (squash) begin
      slot_valid     <= '0;
      bus.write_data <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i] && (bus.req_data[i].prn != '0)) begin
          slot_valid[i] <= 1'b1;
          slot_data[i]  <= bus.req_data[i];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      bus.write_data <= lane_next;
      rr_ptr         <= rr_next;
    end
  end

`ifdef PRF_WB_ARB_STATS_EN
  // Saturating counters; squash discards grants but still sees oversubscription
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      if (!squash) begin
        if (stat_grants > (32'hFFFF_FFFF - 32'(grant_cnt))) begin
          stat_grants <= 32'hFFFF_FFFF;
        end else begin
          stat_grants <= stat_grants + 32'(grant_cnt);
        end
      end
      if ((int'(valid_cnt) > LANES) && (stat_conflicts != 32'hFFFF_FFFF)) begin
        stat_conflicts <= stat_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// tb/tb_prf_wb_arbiter.sv - scoreboard bench for prf_wb_arbiter (NUM_REQ=6, two lanes)
`ifndef N
`define N 2
`endif

module tb_prf_wb_arbiter;
  import prf_wb_arbiter_pkg::*;

  localparam int NR    = 6;
  localparam int LANES = `N;

  logic clock;
  logic reset;
  logic squash;

  prf_wb_arbiter_if #(.NUM_REQ(NR), .N_LANES(LANES)) bus ();

`ifdef PRF_WB_ARB_STATS_EN
  logic [31:0] stat_grants;
  logic [31:0] stat_conflicts;
`endif

  prf_wb_arbiter #(.NUM_REQ(NR)) dut (
    .clock  (clock),
    .reset  (reset),
    .squash (squash),
    .bus    (bus)
`ifdef PRF_WB_ARB_STATS_EN
    ,
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  int errors = 0;
  int checks = 0;
  PRF_WRITE exp_q[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic PRF_WRITE mk(input DATA v, input PRN p);
    PRF_WRITE w;
    w.value = v;
    w.prn   = p;
    return w;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every non-idle lane must match an outstanding expected result
  always @(negedge clock) begin
    bit found;
    for (int l = 0; l < LANES; l++) begin
      if (bus.write_data[l].prn != '0) begin
        found = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
          if (!found && exp_q[j] == bus.write_data[l]) begin
            exp_q.delete(j);
            found = 1'b1;
          end
        end
        checks++;
        if (found !== 1'b1) begin
          errors++;
          $display("FAIL sb_write lane%0d: got prn=%0d value=%h, required an outstanding expected result",
                   l, bus.write_data[l].prn, bus.write_data[l].value);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    squash = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    tick();
    tick();
    checks++;
    if (bus.req_ready !== 6'b000000) begin
      errors++; $display("FAIL reset_ready: got %b required 000000", bus.req_ready);
    end
    checks++;
    if (bus.write_data !== '0) begin
      errors++; $display("FAIL reset_write_data: got %h required 0", bus.write_data);
    end
    checks++;
    if (bus.pending_count !== 3'd0) begin
      errors++; $display("FAIL reset_pending: got %0d required 0", bus.pending_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 6'b111111) begin
      errors++; $display("FAIL post_reset_ready: got %b required 111111", bus.req_ready);
    end
  endtask

  task automatic test_single();
    bus.req_valid[0] = 1'b1;
    bus.req_data[0]  = mk(32'hDEAD, 6'd40);
    #1;
    checks++;
    if (bus.req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL single_ready: got %b required 1", bus.req_ready[0]);
    end
    exp_q.push_back(mk(32'hDEAD, 6'd40));
    tick();
    bus.req_valid = '0;
    bus.req_data  = '0;
    checks++;
    if (bus.pending_count !== 3'd1) begin
      errors++; $display("FAIL single_pending1: got %0d required 1", bus.pending_count);
    end
    tick();
    checks++;
    if (bus.write_data[0] !== mk(32'hDEAD, 6'd40)) begin
      errors++; $display("FAIL single_lane0: got %h required %h", bus.write_data[0], mk(32'hDEAD, 6'd40));
    end
    checks++;
    if (bus.write_data[1].prn !== 6'd0) begin
      errors++; $display("FAIL single_lane1: got prn=%0d required 0", bus.write_data[1].prn);
    end
    checks++;
    if (bus.pending_count !== 3'd0) begin
      errors++; $display("FAIL single_pending0: got %0d required 0", bus.pending_count);
    end
    tick();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL single_drain: got %0d outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_oversub();
    PRN exp_lo[3] = '{6'd33, 6'd35, 6'd37};
    logic [2:0] exp_ptr[3] = '{3'd2, 3'd4, 3'd0};
    logic [2:0] exp_pend[3] = '{3'd4, 3'd2, 3'd0};
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_data[i]  = mk(32'h1000 + 32'(i), PRN'(33 + i));
      exp_q.push_back(mk(32'h1000 + 32'(i), PRN'(33 + i)));
    end
    tick();
    bus.req_valid = '0;
    bus.req_data  = '0;
    checks++;
    if (dut.rr_ptr !== 3'd0 || bus.pending_count !== 3'd6) begin
      errors++; $display("FAIL oversub_accept: got ptr=%0d pend=%0d required ptr=0 pend=6", dut.rr_ptr, bus.pending_count);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.write_data[0].prn !== exp_lo[c] || bus.write_data[1].prn !== exp_lo[c] + 6'd1) begin
        errors++; $display("FAIL oversub_lanes c%0d: got %0d/%0d required %0d/%0d", c,
                           bus.write_data[0].prn, bus.write_data[1].prn, exp_lo[c], exp_lo[c] + 6'd1);
      end
      checks++;
      if (dut.rr_ptr !== exp_ptr[c] || bus.pending_count !== exp_pend[c]) begin
        errors++; $display("FAIL oversub_ptr c%0d: got ptr=%0d pend=%0d required ptr=%0d pend=%0d", c,
                           dut.rr_ptr, bus.pending_count, exp_ptr[c], exp_pend[c]);
      end
    end
    tick();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL oversub_drain: got %0d outstanding required 0", exp_q.size());
    end
`ifdef PRF_WB_ARB_STATS_EN
    checks++;
    if (stat_grants !== 32'd6 || stat_conflicts !== 32'd2) begin
      errors++; $display("FAIL oversub_stats: got grants=%0d conflicts=%0d required 6/2", stat_grants, stat_conflicts);
    end
`endif
  endtask

  task automatic test_back_to_back();
    PRF_WRITE cur[NR];
    bit acc_now[NR];
    int acc5 = 0;
    int run5 = 0;
    int max_run5 = 0;
    int seq = 0;
    for (int i = 0; i < NR; i++) begin
      seq++;
      cur[i] = mk(32'h2000 + 32'(seq), PRN'((seq % 63) + 1));
      bus.req_data[i]  = cur[i];
      bus.req_valid[i] = 1'b1;
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
        acc_now[i] = bus.req_ready[i];
        if (bus.req_ready[i]) exp_q.push_back(cur[i]);
        checks++;
        if (!bus.req_ready[i] && dut.slot_valid[i] !== 1'b1) begin
          errors++; $display("FAIL b2b_ready_held req%0d c%0d: ready=0 with empty slot", i, c);
        end
      end
      if (bus.req_ready[5]) begin
        acc5++;
        run5 = 0;
      end else begin
        run5++;
        if (run5 > max_run5) max_run5 = run5;
      end
      tick();
      for (int i = 0; i < NR; i++) begin
        if (acc_now[i]) begin
          seq++;
          cur[i] = mk(32'h2000 + 32'(seq), PRN'((seq % 63) + 1));
          bus.req_data[i] = cur[i];
        end
      end
    end
    bus.req_valid = '0;
    bus.req_data  = '0;
    for (int c = 0; c < 5; c++) tick();
    checks++;
    if (max_run5 > 2) begin
      errors++; $display("FAIL b2b_fairness: got %0d-cycle stall for req5 required at most 2", max_run5);
    end
    checks++;
    if (acc5 < 4) begin
      errors++; $display("FAIL b2b_req5_accepts: got %0d required at least 4", acc5);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL b2b_drain: got %0d outstanding required 0", exp_q.size());
    end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = 1'b1;
      bus.req_data[i]  = mk(32'h3000 + 32'(i), PRN'(10 + i));
    end
    tick();
    bus.req_valid = '0;
    bus.req_data  = '0;
    squash = 1'b1;
    #1;
    checks++;
    if (bus.pending_count !== 3'd4 || bus.req_ready !== 6'b000000) begin
      errors++; $display("FAIL squash_pre: got pend=%0d ready=%b required 4/000000", bus.pending_count, bus.req_ready);
    end
    tick();
    squash = 1'b0;
    checks++;
    if (bus.write_data !== '0 || bus.pending_count !== 3'd0) begin
      errors++; $display("FAIL squash_post: got lanes=%h pend=%0d required 0/0", bus.write_data, bus.pending_count);
    end
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_prn0();
    bus.req_valid[2] = 1'b1;
    bus.req_data[2]  = mk(32'h55, 6'd0);
    #1;
    checks++;
    if (bus.req_ready[2] !== 1'b1) begin
      errors++; $display("FAIL prn0_ready: got %b required 1", bus.req_ready[2]);
    end
    tick();
    bus.req_valid = '0;
    bus.req_data  = '0;
    checks++;
    if (bus.pending_count !== 3'd0) begin
      errors++; $display("FAIL prn0_pending: got %0d required 0", bus.pending_count);
    end
    tick();
    checks++;
    if (bus.write_data !== '0) begin
      errors++; $display("FAIL prn0_lanes: got %h required 0", bus.write_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_oversub();
    test_back_to_back();
    test_squash();
    test_prn0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
